// File: rtl/reg_bank_np.sv
// reg_bank_np: N x D flip-flop register bank with sequential clear sweep; define REG_BANK_NP_BYPASS_EN for write-through read forwarding
module reg_bank_np #(
    parameter int N = 8,
    parameter int D = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_we,
    input  logic [$clog2(N)-1:0] i_waddr,
    input  logic [D-1:0]         i_d,
    input  logic [$clog2(N)-1:0] i_raddr,
    input  logic                 i_clr,
    output logic [D-1:0]         o_q,
    output logic [D-1:0]         o_regs [N],
    output logic                 o_busy
);
    localparam int AW = $clog2(N);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t        r_state, w_state_nx;
    logic [AW-1:0] r_cnt, w_cnt_nx;
    logic [D-1:0]  r_mem [N];
    logic          r_busy;
    logic [N-1:0]  w_whit, w_rhit;
    logic          w_wr, w_last;
    logic [D-1:0]  w_q;
    // address decode; an address with no matching word reads 0 and writes nothing
    always_comb begin
        w_q = '0;
        for (int i = 0; i < N; i++) begin
            w_rhit[i] = i_raddr == AW'(i);
            w_whit[i] = i_waddr == AW'(i);
            if (w_rhit[i]) w_q = r_mem[i];
        end
    end
    assign w_wr   = i_we && !i_clr && r_state == IDLE && |w_whit;
    assign w_last = r_cnt == AW'(N - 1);
`ifdef REG_BANK_NP_BYPASS_EN
    assign o_q = (w_wr && i_waddr == i_raddr) ? i_d : w_q;
`else
    assign o_q = w_q;
`endif
    assign o_regs = r_mem;
    assign o_busy = r_busy;
    // next state: clear request wins in IDLE, sweep ends after word N-1
    always_comb begin
        w_state_nx = (r_state == IDLE) ? (i_clr ? CLEAR : IDLE) : (w_last ? IDLE : CLEAR);
        w_cnt_nx   = (r_state == CLEAR && !w_last) ? r_cnt + 1'b1 : '0;
    end
    // state, sweep counter and registered busy flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_busy  <= w_state_nx == CLEAR;
        end
    end
    // word storage: writes in IDLE, one word zeroed per sweep cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N; i++) r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_wr && w_whit[i]) r_mem[i] <= i_d;
                else if (r_state == CLEAR && r_cnt == AW'(i)) r_mem[i] <= '0;
            end
        end
    end
endmodule

// File: doc/reg_bank_np.md
REG_BANK_NP -- requirements
Module: reg_bank_np

Interface
REQ-001 SHALL have parameter N, default 8: number of words; legal range N >= 2.
REQ-002 SHALL have parameter D, default 16: bit width of each word.
REQ-003 SHALL have port i_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port i_we, input, 1: write enable.
REQ-006 SHALL have port i_waddr, input, $clog2(N): write address.
REQ-007 SHALL have port i_d, input, D: write data.
REQ-008 SHALL have port i_raddr, input, $clog2(N): read address.
REQ-009 SHALL have port i_clr, input, 1: request to start a sequential clear of all words.
REQ-010 SHALL have port o_q, output, D: read data for i_raddr.
REQ-011 SHALL have port o_regs, output, unpacked array of N words, D bits each: all word contents, index i = word i, in the layout a mux_np i_mux input expects.
REQ-012 SHALL have port o_busy, output, 1: high while a clear sweep is running.

Function
REQ-013 SHALL store N words of D bits in flip-flops.
REQ-014 SHALL drive o_regs[i] continuously from word i, with zero added latency.
REQ-015 SHALL make o_q combinational from i_raddr: o_q = word[i_raddr].
REQ-016 SHALL drive o_q to 0 when i_raddr >= N (non-power-of-2 N).
REQ-017 SHALL, in IDLE with i_we=1, i_clr=0 and i_waddr < N, write i_d to word[i_waddr] at the clock edge; the new value is visible on o_q and o_regs the following cycle.
REQ-018 SHALL ignore a write with i_waddr >= N: no word changes.
REQ-019 SHALL implement an FSM with states IDLE (reset state) and CLEAR, plus a $clog2(N)-bit sweep counter.
REQ-020 SHALL, when i_clr=1 in IDLE, go to CLEAR with the counter at 0; i_clr has priority, so a write in that same cycle is dropped.
REQ-021 SHALL, in CLEAR, zero word[counter] each cycle and increment the counter.
REQ-022 SHALL, when counter = N-1 in CLEAR, zero that word and return to IDLE, so a sweep lasts exactly N cycles.
REQ-023 SHALL drive o_busy as a registered output, high exactly in CLEAR: it rises the cycle after i_clr is accepted and stays high for N cycles.
REQ-024 SHALL, in CLEAR, ignore i_we and i_clr; a dropped write is not retried.
REQ-025 SHALL, in CLEAR, let reads return the current contents, so words at or above the counter still hold their old values.
REQ-026 SHALL accept a new i_clr in the first IDLE cycle after a sweep ends.

Reset
REQ-027 SHALL, on i_rst_n=0, immediately and independent of i_clk, set all words, the counter and o_busy to 0 and the FSM to IDLE.
REQ-028 SHALL, on reset asserted mid-sweep, abort the sweep and zero all words immediately.
REQ-029 SHALL, after reset, output o_q=0, every o_regs word = 0 and o_busy=0.
REQ-030 SHALL accept the first write at the first clock edge after i_rst_n deasserts.

Configuration
REQ-031 SHALL, when macro REG_BANK_NP_BYPASS_EN is defined, add write-through forwarding: if i_we=1, i_waddr=i_raddr < N and the FSM is IDLE with i_clr=0, o_q = i_d combinationally in that same cycle.
REQ-032 SHALL leave o_regs unaffected by forwarding; o_regs always shows stored words.
REQ-033 SHALL, when REG_BANK_NP_BYPASS_EN is undefined, provide no forwarding: o_q always shows stored contents, and a write is visible one cycle later.

Verification (N=8, D=16)
REQ-034 SHALL cover reset: drop i_rst_n with no clock running -> o_q=0x0000, all o_regs=0, o_busy=0.
REQ-035 SHALL cover write/read: write 0xBEEF to addr 3, then set i_raddr=3 next cycle -> o_q=0xBEEF, o_regs[3]=0xBEEF, all other words 0.
REQ-036 SHALL cover the clear sweep: load words 0..7 with 0x1111*(i+1), pulse i_clr -> o_busy high for exactly 8 cycles; word k reads 0 from sweep cycle k+1 onward; all words 0 at the end.
REQ-037 SHALL cover writes during clear: i_we=1, addr 6, data 0xAAAA in sweep cycle 2 -> write dropped, word 6 = 0 after the sweep; a write in the same cycle as i_clr is also dropped.
REQ-038 SHALL cover bypass: same-cycle write 0x1234 to addr 5 with i_raddr=5 -> o_q=0x1234 in that cycle with the macro defined; old value shown without the macro.
REQ-039 SHALL cover reset mid-sweep: assert i_rst_n=0 in sweep cycle 4 -> o_busy=0 and all words 0 at once; a write to addr 1 of 0x0F0F after release is stored normally.
